// File: rtl/calc_entry_ctrl_if.sv
// Keypad-to-calculator entry bus: raw key strobes in, sequencer state and
// BCD operands out. The master is the keypad/arithmetic side, the slave the controller.
interface calc_entry_ctrl_if #(
  parameter int DIGITS = 4
) ();
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic [3:0]          key;
  logic                key_valid;
  logic [1:0]          state;
  logic [4*DIGITS-1:0] operand_a;
  logic [4*DIGITS-1:0] operand_b;
  logic [1:0]          op;
  logic                calc_start;
  logic [CNT_W-1:0]    digit_count;
  logic                digit_overflow;
  logic                disp_sel;

  modport master (
    output key, key_valid,
    input  state, operand_a, operand_b, op, calc_start,
    input  digit_count, digit_overflow, disp_sel
  );

  modport slave (
    input  key, key_valid,
    output state, operand_a, operand_b, op, calc_start,
    output digit_count, digit_overflow, disp_sel
  );
endinterface

// File: rtl/calc_entry_ctrl.sv
// Keypad entry sequencer for the calculator: builds two BCD operands and an
// operator from hex key codes and pulses calc_start on equals.
module calc_entry_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  calc_entry_ctrl_if.slave  bus
);
  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

  localparam logic [3:0] KEY_EQ = 4'hD;
  localparam logic [3:0] KEY_CE = 4'hE;
  localparam logic [3:0] KEY_CA = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ENT_A = 2'b01,
    ST_OP    = 2'b10,
    ST_ENT_B = 2'b11
  } state_t;

  state_t           state_r;
  logic [W-1:0]     operand_a_r;
  logic [W-1:0]     operand_b_r;
  logic [1:0]       op_r;
  logic             calc_start_r;
  logic [CNT_W-1:0] digit_count_r;
  logic             digit_overflow_r;
  logic             disp_sel_r;

  logic             is_digit_s;
  logic             is_op_s;
  logic [1:0]       op_code_s;
  logic [W-1:0]     digit_ext_s;
  logic [W-1:0]     cur_opnd_s;
  logic [W-1:0]     entry_val_s;
  logic [CNT_W-1:0] entry_cnt_s;
  logic             entry_full_s;

  // Append one BCD digit at the least significant end; the top digit falls off.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] d);
    logic [W+3:0] t;
    t = {v, d};
    return t[W-1:0];
  endfunction

  // Number of significant digits in an operand; a zero operand still counts as one digit.
  function automatic logic [CNT_W-1:0] digit_len(input logic [W-1:0] v);
    logic [CNT_W-1:0] n;
    n = CNT_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'h0) begin
        n = CNT_W'(i + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Key decode and the candidate result of entering a digit into the active operand.
  always_comb begin
    is_digit_s   = (bus.key <= 4'd9);
    is_op_s      = (bus.key >= 4'hA) && (bus.key <= 4'hC);
    op_code_s    = bus.key[1:0] + 2'd2;   // A->00, B->01, C->10
    digit_ext_s  = W'(bus.key);
    cur_opnd_s   = (state_r == ST_ENT_B) ? operand_b_r : operand_a_r;
    entry_val_s  = cur_opnd_s;
    entry_cnt_s  = digit_count_r;
    entry_full_s = 1'b0;
    if ((digit_count_r == CNT_W'(1)) && (cur_opnd_s == {W{1'b0}})) begin
      entry_val_s = digit_ext_s;
    end else if (digit_count_r == CNT_W'(DIGITS)) begin
      entry_full_s = 1'b1;
    end else begin
      entry_val_s = shift_in(cur_opnd_s, bus.key);
      entry_cnt_s = digit_count_r + CNT_W'(1);
    end
  end

  // Operand/operator sequencer with registered outputs and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      operand_a_r      <= {W{1'b0}};
      operand_b_r      <= {W{1'b0}};
      op_r             <= 2'b00;
      calc_start_r     <= 1'b0;
      digit_count_r    <= {CNT_W{1'b0}};
      digit_overflow_r <= 1'b0;
      disp_sel_r       <= 1'b0;
    end else begin
      calc_start_r     <= 1'b0;
      digit_overflow_r <= 1'b0;
      if (!bus.key_valid) begin
        state_r <= state_r;
      end else if (bus.key == KEY_CA) begin
        state_r       <= ST_IDLE;
        operand_a_r   <= {W{1'b0}};
        operand_b_r   <= {W{1'b0}};
        op_r          <= 2'b00;
        digit_count_r <= {CNT_W{1'b0}};
        disp_sel_r    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (is_digit_s) begin
              operand_a_r   <= digit_ext_s;
              operand_b_r   <= {W{1'b0}};
              op_r          <= 2'b00;
              digit_count_r <= CNT_W'(1);
              state_r       <= ST_ENT_A;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_ENT_A: begin
            if (is_digit_s) begin
              operand_a_r      <= entry_val_s;
              digit_count_r    <= entry_cnt_s;
              digit_overflow_r <= entry_full_s;
            end else if (is_op_s) begin
              op_r          <= op_code_s;
              digit_count_r <= {CNT_W{1'b0}};
              state_r       <= ST_OP;
            end else if (bus.key == KEY_CE) begin
              operand_a_r   <= {W{1'b0}};
              digit_count_r <= {CNT_W{1'b0}};
              state_r       <= ST_IDLE;
            end else begin
              state_r <= ST_ENT_A;
            end
          end
          ST_OP: begin
            if (is_digit_s) begin
              operand_b_r   <= digit_ext_s;
              digit_count_r <= CNT_W'(1);
              disp_sel_r    <= 1'b1;
              state_r       <= ST_ENT_B;
            end else if (is_op_s) begin
              op_r <= op_code_s;
            end else if (bus.key == KEY_CE) begin
              // Back to editing A: count reflects the digits A already holds.
              digit_count_r <= digit_len(operand_a_r);
              state_r       <= ST_ENT_A;
            end else begin
              state_r <= ST_OP;
            end
          end
          ST_ENT_B: begin
            if (is_digit_s) begin
              operand_b_r      <= entry_val_s;
              digit_count_r    <= entry_cnt_s;
              digit_overflow_r <= entry_full_s;
            end else if (bus.key == KEY_EQ) begin
              calc_start_r  <= 1'b1;
              digit_count_r <= {CNT_W{1'b0}};
              disp_sel_r    <= 1'b0;
              state_r       <= ST_IDLE;
            end else if (bus.key == KEY_CE) begin
              operand_b_r   <= {W{1'b0}};
              digit_count_r <= {CNT_W{1'b0}};
              disp_sel_r    <= 1'b0;
              state_r       <= ST_OP;
            end else begin
              state_r <= ST_ENT_B;
            end
          end
          default: begin
            state_r       <= ST_IDLE;
            operand_a_r   <= {W{1'b0}};
            operand_b_r   <= {W{1'b0}};
            op_r          <= 2'b00;
            digit_count_r <= {CNT_W{1'b0}};
            disp_sel_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.state          = state_r;
  assign bus.operand_a      = operand_a_r;
  assign bus.operand_b      = operand_b_r;
  assign bus.op             = op_r;
  assign bus.calc_start     = calc_start_r;
  assign bus.digit_count    = digit_count_r;
  assign bus.digit_overflow = digit_overflow_r;
  assign bus.disp_sel       = disp_sel_r;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed self-checking bench for calc_entry_ctrl with DIGITS=4 and
// hand-computed expected values.
module tb_calc_entry_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  calc_entry_ctrl_if #(.DIGITS(4)) bus ();

  calc_entry_ctrl #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.key       = k;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key       = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(bus.state), 32'h0);
    check({tag, "_a"}, 32'(bus.operand_a), 32'h0);
    check({tag, "_b"}, 32'(bus.operand_b), 32'h0);
    check({tag, "_op"}, 32'(bus.op), 32'h0);
    check({tag, "_start"}, 32'(bus.calc_start), 32'h0);
    check({tag, "_cnt"}, 32'(bus.digit_count), 32'h0);
    check({tag, "_ovf"}, 32'(bus.digit_overflow), 32'h0);
    check({tag, "_disp"}, 32'(bus.disp_sel), 32'h0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.key       = 4'h0;
    bus.key_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_values("rst");

    // 1 2 A 3 D : basic addition sequence
    press(4'h1);
    check("t1_s1", 32'(bus.state), 32'h1);
    check("t1_a1", 32'(bus.operand_a), 32'h1);
    press(4'h2);
    check("t1_a12", 32'(bus.operand_a), 32'h12);
    check("t1_cnt2", 32'(bus.digit_count), 32'h2);
    press(4'hA);
    check("t1_sop", 32'(bus.state), 32'h2);
    check("t1_cnt0", 32'(bus.digit_count), 32'h0);
    press(4'h3);
    check("t1_sb", 32'(bus.state), 32'h3);
    check("t1_b3", 32'(bus.operand_b), 32'h3);
    check("t1_disp1", 32'(bus.disp_sel), 32'h1);
    press(4'hD);
    check("t1_sidle", 32'(bus.state), 32'h0);
    check("t1_start", 32'(bus.calc_start), 32'h1);
    check("t1_a", 32'(bus.operand_a), 32'h12);
    check("t1_b", 32'(bus.operand_b), 32'h3);
    check("t1_op", 32'(bus.op), 32'h0);
    check("t1_disp0", 32'(bus.disp_sel), 32'h0);
    tick();
    check("t1_start_drop", 32'(bus.calc_start), 32'h0);
    check("t1_a_hold", 32'(bus.operand_a), 32'h12);

    // 9 8 7 6 5 : fifth digit overflows
    press(4'h9);
    check("t2_b_clr", 32'(bus.operand_b), 32'h0);
    press(4'h8);
    press(4'h7);
    press(4'h6);
    check("t2_a4", 32'(bus.operand_a), 32'h9876);
    check("t2_ovf0", 32'(bus.digit_overflow), 32'h0);
    press(4'h5);
    check("t2_a5", 32'(bus.operand_a), 32'h9876);
    check("t2_ovf1", 32'(bus.digit_overflow), 32'h1);
    check("t2_cnt", 32'(bus.digit_count), 32'h4);
    check("t2_state", 32'(bus.state), 32'h1);
    tick();
    check("t2_ovf_drop", 32'(bus.digit_overflow), 32'h0);
    press(4'hF);
    check_reset_values("t2_clr");

    // 0 0 7 C B : leading zeros, operator overwrite
    press(4'h0);
    check("t3_s", 32'(bus.state), 32'h1);
    press(4'h0);
    check("t3_cnt0", 32'(bus.digit_count), 32'h1);
    press(4'h7);
    check("t3_a", 32'(bus.operand_a), 32'h7);
    check("t3_cnt", 32'(bus.digit_count), 32'h1);
    press(4'hC);
    check("t3_opc", 32'(bus.op), 32'h2);
    press(4'hB);
    check("t3_opb", 32'(bus.op), 32'h1);
    check("t3_state", 32'(bus.state), 32'h2);
    press(4'hF);

    // 4 2 A 5 E E 1 : clear-entry walking back to A
    press(4'h4);
    press(4'h2);
    press(4'hA);
    press(4'h5);
    check("t4_b5", 32'(bus.operand_b), 32'h5);
    press(4'hE);
    check("t4_b0", 32'(bus.operand_b), 32'h0);
    check("t4_sop", 32'(bus.state), 32'h2);
    check("t4_disp", 32'(bus.disp_sel), 32'h0);
    press(4'hE);
    check("t4_sa", 32'(bus.state), 32'h1);
    check("t4_cnt", 32'(bus.digit_count), 32'h2);
    press(4'h1);
    check("t4_a", 32'(bus.operand_a), 32'h421);
    check("t4_cnt3", 32'(bus.digit_count), 32'h3);

    // D ignored outside ENT_B
    press(4'hD);
    check("t5_d_enta_start", 32'(bus.calc_start), 32'h0);
    check("t5_d_enta_state", 32'(bus.state), 32'h1);
    press(4'hF);
    press(4'hD);
    check("t5_d_idle_start", 32'(bus.calc_start), 32'h0);
    check("t5_d_idle_state", 32'(bus.state), 32'h0);
    press(4'h7);
    press(4'hA);
    press(4'hD);
    check("t5_d_op_start", 32'(bus.calc_start), 32'h0);
    check("t5_d_op_state", 32'(bus.state), 32'h2);
    press(4'hF);

    // 5 B 6 then F together with rst
    press(4'h5);
    press(4'hB);
    press(4'h6);
    check("t6_b6", 32'(bus.operand_b), 32'h6);
    @(negedge clk);
    rst           = 1'b1;
    bus.key       = 4'hF;
    bus.key_valid = 1'b1;
    tick();
    rst           = 1'b0;
    bus.key_valid = 1'b0;
    check_reset_values("t6_rstF");

    // rst wins over a digit that would otherwise start entry
    @(negedge clk);
    rst           = 1'b1;
    bus.key       = 4'h3;
    bus.key_valid = 1'b1;
    tick();
    rst           = 1'b0;
    bus.key_valid = 1'b0;
    check("t6_rst_dig_state", 32'(bus.state), 32'h0);
    check("t6_rst_dig_a", 32'(bus.operand_a), 32'h0);

    // keys with key_valid low change nothing
    press(4'h5);
    @(negedge clk);
    bus.key = 4'h8;
    tick();
    tick();
    bus.key = 4'hD;
    tick();
    check("t7_a", 32'(bus.operand_a), 32'h5);
    check("t7_cnt", 32'(bus.digit_count), 32'h1);
    check("t7_state", 32'(bus.state), 32'h1);
    check("t7_start", 32'(bus.calc_start), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
Clocked keypad-entry controller for the digital calculator. It consumes 4-bit hex key codes: 0-9 are digits; A, B and C are operators; D is equals; E is clear-entry; F is clear-all. It runs a four-state operand/operator sequencer and accumulates multi-digit BCD operands, up to DIGITS per operand. It hands the operands and operator to the arithmetic unit with a one-cycle start pulse on equals.

Parameters:
DIGITS, 4, max BCD digits per operand (legal 1..8)
CNT_W, $clog2(DIGITS+1), localparam, width of digit counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
key  in  4  key code, sampled only when key_valid=1
key_valid  in  1  one-cycle strobe per debounced key press
state  out  2  00 IDLE, 01 ENT_A, 10 OP, 11 ENT_B
operand_a  out  4*DIGITS  BCD operand A, most significant digit at top
operand_b  out  4*DIGITS  BCD operand B
op  out  2  00 add (A), 01 sub (B), 10 mul (C)
calc_start  out  1  one-cycle pulse, operands/op valid
digit_count  out  CNT_W  digits held in the operand currently being entered
digit_overflow  out  1  one-cycle pulse, digit rejected because the operand is full
disp_sel  out  1  0 display operand_a, 1 display operand_b

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE; operand_a=0; operand_b=0; op=00; calc_start=0; digit_count=0; digit_overflow=0; disp_sel=0.
- rst has priority over key_valid in the same cycle. Reset mid-entry discards all operands.
- When key_valid=0, all registers hold. calc_start and digit_overflow drop to 0 after one cycle.
- Latency: a key sampled at edge n is reflected in the outputs after edge n. calc_start is high exactly for the cycle following the D edge.
- "Shift in digit d": operand <= {operand[4*DIGITS-5:0], d}, digit_count+1.
- Leading-zero rule: if digit_count==1 and the operand is 0, the new digit replaces it and digit_count stays 1.
- "Full": digit_count==DIGITS. On a digit while full: operand unchanged, digit_overflow=1 for one cycle, state unchanged.
- IDLE:
  - digit d: operand_a=d, operand_b=0, op=00, digit_count=1, go to ENT_A.
  - A-E: ignored.
  - F: clear all, stay in IDLE.
- ENT_A:
  - digit: shift into operand_a (full/leading-zero rules apply).
  - A/B/C: latch op, digit_count=0, go to OP.
  - D: ignored.
  - E: operand_a=0, digit_count=0, go to IDLE.
  - F: clear all, go to IDLE.
- OP:
  - digit d: operand_b=d, digit_count=1, go to ENT_B.
  - A/B/C: overwrite op, stay in OP.
  - D: ignored.
  - E: restore digit_count to the digit length of operand_a, go to ENT_A.
  - F: clear all, go to IDLE.
- ENT_B:
  - digit: shift into operand_b.
  - A/B/C: ignored.
  - D: calc_start=1, digit_count=0, go to IDLE. operand_a, operand_b and op hold until the next digit in IDLE.
  - E: operand_b=0, digit_count=0, go to OP.
  - F: clear all, go to IDLE.
- Codes 1010-1111 are never stored as digits.
- disp_sel=1 only in ENT_B.

Test Plan:
- Reset, then keys 1,2,A,3,D → state path IDLE→ENT_A→ENT_A→OP→ENT_B→IDLE; operand_a=0x0012, operand_b=0x0003, op=00; calc_start high one cycle, on the cycle after D.
- DIGITS=4, keys 9,8,7,6,5 → operand_a=0x9876; digit_overflow pulses on the fifth key; digit_count=4.
- Keys 0,0,7 → operand_a=0x0007, digit_count=1; then C, then B → op=01, state=OP.
- Keys 4,2,A,5,E → operand_b=0, state=OP; then E again → state=ENT_A, digit_count=2; then 1 → operand_a=0x0421.
- Keys 5,B,6, then F asserted in the same cycle as rst → all outputs at reset values; keys with key_valid=0 cause no change; D in IDLE/ENT_A/OP does not pulse calc_start.
